// File: rtl/led_bank_arbiter.sv
// led_bank_arbiter: round-robin sharing of one 8-LED bank among four pattern sources with a tick-based minimum hold
module led_bank_arbiter #(
   parameter int          CLK_DIV    = 12000,
   parameter int          HOLD_TICKS = 250,
   parameter logic [7:0]  IDLE_PAT   = 8'h00
) (
   input  logic       CLK_i,
   input  logic       RST_i,
   input  logic [3:0] REQ_i,
   input  logic [7:0] PAT0_i,
   input  logic [7:0] PAT1_i,
   input  logic [7:0] PAT2_i,
   input  logic [7:0] PAT3_i,
   output logic [3:0] GNT_o,
   output logic [7:0] LED_o,
   output logic       BUSY_o,
   output logic       TICK_o
);
   localparam int CW = $clog2(CLK_DIV);
   localparam int HW = $clog2(HOLD_TICKS + 1);
   typedef enum logic {IDLE, GRANT} state_t;
   state_t         state;
   logic [CW-1:0]  div_cnt;
   logic [HW-1:0]  hold;
   logic [1:0]     last;
   logic [1:0]     sel;
   logic [7:0]     pat [4];
   logic           at_top;
   logic           drop;
   assign pat[0] = PAT0_i;
   assign pat[1] = PAT1_i;
   assign pat[2] = PAT2_i;
   assign pat[3] = PAT3_i;
   assign at_top = div_cnt == CW'(CLK_DIV - 1);
   // the owner is always the last-granted requester, so last doubles as the owner index
   assign drop = !REQ_i[last] || (hold == '0 && (REQ_i & ~(4'b0001 << last)) != 4'b0000);
   // round-robin pick: first requester after last, the smallest offset wins
   always_comb begin
      sel = last + 2'd1;
      for (int i = 4; i >= 1; i--)
         if (REQ_i[last + 2'(i)]) sel = last + 2'(i);
   end
   // free-running prescaler with a registered one-cycle tick after the terminal count
   always_ff @(posedge CLK_i) begin
      if (RST_i) begin
         div_cnt <= '0;
         TICK_o  <= 1'b0;
      end else begin
         div_cnt <= at_top ? '0 : div_cnt + 1'b1;
         TICK_o  <= at_top;
      end
   end
   // grant FSM: arbitrate from IDLE, hold the bank, release on owner drop or expired-hold contention
   always_ff @(posedge CLK_i) begin
      if (RST_i) begin
         state  <= IDLE;
         GNT_o  <= 4'b0000;
         LED_o  <= IDLE_PAT;
         BUSY_o <= 1'b0;
         last   <= 2'd3;
         hold   <= '0;
      end else if (state == IDLE) begin
         if (REQ_i != 4'b0000) begin
            state  <= GRANT;
            GNT_o  <= 4'b0001 << sel;
            LED_o  <= pat[sel];
            BUSY_o <= 1'b1;
            last   <= sel;
            hold   <= HW'(HOLD_TICKS);
         end else begin
            LED_o  <= IDLE_PAT;
         end
      end else if (drop) begin
         state  <= IDLE;
         GNT_o  <= 4'b0000;
         LED_o  <= IDLE_PAT;
         BUSY_o <= 1'b0;
      end else begin
         LED_o  <= pat[last];
         if (TICK_o && hold != '0) hold <= hold - 1'b1;
      end
   end
endmodule

// File: tb/tb_led_bank_arbiter.sv
// tb_led_bank_arbiter: directed checks of prescaler, rotation, hold, early release, preemption and reset
module tb_led_bank_arbiter;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] req = 4'b0000;
   logic [7:0] pat0 = 8'h11, pat1 = 8'h22, pat2 = 8'h44, pat3 = 8'h88;
   logic [3:0] gnt;
   logic [7:0] led;
   logic       busy, tick;
   int checks = 0;
   int errors = 0;
   int len, miss;
   logic [3:0] exp_g;

   led_bank_arbiter #(.CLK_DIV(4), .HOLD_TICKS(2), .IDLE_PAT(8'hA5)) dut (
      .CLK_i(clk), .RST_i(rst), .REQ_i(req),
      .PAT0_i(pat0), .PAT1_i(pat1), .PAT2_i(pat2), .PAT3_i(pat3),
      .GNT_o(gnt), .LED_o(led), .BUSY_o(busy), .TICK_o(tick)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1);
   end

   initial begin
      // 1: reset values, idle pattern, tick cadence
      step();
      step();
      check("rst_gnt", gnt, 4'b0000);
      check("rst_led", led, 8'hA5);
      check("rst_busy", busy, 1'b0);
      check("rst_tick", tick, 1'b0);
      rst = 1'b0;
      for (int n = 1; n <= 20; n++) begin
         step();
         check("idle_tick", tick, (n % 4 == 0));
      end
      check("idle_gnt", gnt, 4'b0000);
      check("idle_led", led, 8'hA5);
      check("idle_busy", busy, 1'b0);

      // 2: single grant and live pattern tracking
      req = 4'b0001;
      pat0 = 8'h3C;
      step();
      check("g0_gnt", gnt, 4'b0001);
      check("g0_busy", busy, 1'b1);
      check("g0_led", led, 8'h3C);
      pat0 = 8'hFF;
      step();
      check("g0_led_upd", led, 8'hFF);
      pat0 = 8'h11;
      req = 4'b0000;
      step();
      check("g0_rel_gnt", gnt, 4'b0000);
      check("g0_rel_led", led, 8'hA5);

      // 3: full contention rotates 0,1,2,3,0; the grant stays visible one cycle past hold expiry
      do_reset();
      req = 4'b1111;
      step();
      for (int g = 0; g < 5; g++) begin
         exp_g = 4'b0001 << (g % 4);
         check("rot_gnt", gnt, exp_g);
         check("rot_led", led, 8'h11 << (g % 4));
         len = 0;
         do begin
            len++;
            step();
         end while (gnt == exp_g && len < 20);
         check("rot_len_ok", (len >= 6 && len <= 9), 1'b1);
         check("rot_gap", gnt, 4'b0000);
         step();
      end

      // 4: lone owner keeps the bank past hold expiry, then a competitor preempts
      req = 4'b0000;
      step();
      check("r4_idle", gnt, 4'b0000);
      req = 4'b0100;
      step();
      check("r4_gnt2", gnt, 4'b0100);
      miss = 0;
      for (int n = 0; n < 48; n++) begin
         step();
         if (gnt != 4'b0100) miss++;
      end
      check("r4_persist_miss", miss, 0);
      req = 4'b0101;
      step();
      check("r4_preempt_gap", gnt, 4'b0000);
      check("r4_gap_busy", busy, 1'b0);
      step();
      check("r4_gnt0", gnt, 4'b0001);
      check("r4_led0", led, 8'h11);

      // 5: early release before the hold expires
      req = 4'b0010;
      step();
      check("r5_gap", gnt, 4'b0000);
      step();
      check("r5_gnt1", gnt, 4'b0010);
      req = 4'b0000;
      step();
      check("r5_early_gnt", gnt, 4'b0000);
      check("r5_early_led", led, 8'hA5);
      check("r5_early_busy", busy, 1'b0);

      // 6: reset mid-grant restores outputs and the pointer
      req = 4'b1000;
      step();
      check("r6_gnt3", gnt, 4'b1000);
      step();
      step();
      rst = 1'b1;
      step();
      check("r6_rst_gnt", gnt, 4'b0000);
      check("r6_rst_led", led, 8'hA5);
      check("r6_rst_busy", busy, 1'b0);
      check("r6_rst_tick", tick, 1'b0);
      rst = 1'b0;
      step();
      check("r6_regnt3", gnt, 4'b1000);
      check("r6_led3", led, 8'h88);
      req = 4'b1001;
      do_reset();
      step();
      check("r6_ptr_gnt0", gnt, 4'b0001);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
